ascii_dec_parser: RTL and testbench
===================================

ASCII_DEC_PARSER -- requirements
Module: ascii_dec_parser

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 16: width of the binary result.
REQ-002 SHALL have parameter SIGNED, default 0: 1 accepts a leading '-' and produces a two's-complement result.
REQ-003 SHALL have parameter MAX_DIGITS, default 5: maximum digit count accepted before overflow.
REQ-004 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port in_data, input, 8: ASCII byte.
REQ-007 SHALL have port in_valid, input, 1: in_data valid.
REQ-008 SHALL have port in_ready, output, 1: byte accepted when in_valid & in_ready.
REQ-009 SHALL have port out_value, output, BIN_WIDTH: parsed result.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: result consumed when out_valid & out_ready.
REQ-012 SHALL have port out_error, output, 1: malformed token flag, qualified by out_valid.
REQ-013 SHALL have port out_overflow, output, 1: range exceeded flag, qualified by out_valid.
REQ-014 SHALL have port out_ndigits, output, clog2(MAX_DIGITS+2): digits seen, saturating at MAX_DIGITS+1.

Function
REQ-015 SHALL implement the states IDLE, NUM, SKIP and DONE.
REQ-016 Terminators SHALL be 0x20, 0x0A and 0x0D; digits SHALL be 0x30-0x39.
REQ-017 IDLE SHALL behave as follows: terminator -> ignored, stay IDLE; digit -> acc=digit, ndigits=1, NUM; '-' with SIGNED=1 -> neg=1, ndigits=0, NUM; any other byte -> error=1, SKIP.
REQ-018 NUM SHALL behave as follows: digit -> acc=acc*10+digit, ndigits++; terminator -> DONE; other byte -> error=1, SKIP.
REQ-019 SKIP SHALL discard bytes until a terminator, then go to DONE.
REQ-020 A terminator reached with ndigits=0 (e.g. lone '-') SHALL set error=1.
REQ-021 The accumulator SHALL be at least BIN_WIDTH+4 bits wide so that acc*10+9 is computed without loss before the range check.
REQ-022 The limit SHALL be: unsigned 2^W-1; signed positive 2^(W-1)-1; signed negative magnitude 2^(W-1).
REQ-023 If the accumulator exceeds the limit, or ndigits exceeds MAX_DIGITS, overflow SHALL be set and the accumulator SHALL saturate at the limit; further digits SHALL be accepted and the accumulator SHALL remain saturated.
REQ-024 In DONE: out_valid=1; out_value = neg ? -acc : acc, truncated to BIN_WIDTH; out_error and out_overflow SHALL be sticky values for the token.
REQ-025 When error=1, out_value SHALL be 0 and out_overflow SHALL be 0.
REQ-026 out_valid SHALL rise the cycle after the terminator is accepted (latency 1).
REQ-027 out_valid and all out_* outputs SHALL hold stable until out_ready; on handshake the block SHALL go to IDLE and clear acc, neg, error, overflow and ndigits.
REQ-028 in_ready SHALL be 1 in IDLE, NUM and SKIP, and 0 in DONE; the next byte SHALL be accepted no earlier than the cycle after the output handshake.
REQ-029 Bytes presented with in_valid=0 SHALL have no effect.
REQ-030 Bytes presented while in_ready=0 SHALL not be consumed; the source holds them.

Reset
REQ-031 When reset_n=0 at a clock edge, the block SHALL enter IDLE with acc=0, neg=0, error=0, overflow=0 and ndigits=0.
REQ-032 During reset, out_valid SHALL be 0, out_value 0, out_error 0, out_overflow 0 and out_ndigits 0; in_ready SHALL be 1 from the first cycle after reset release.
REQ-033 Reset asserted mid-token or in DONE SHALL discard the partial or pending result, with no out_valid after release until a new terminator.
REQ-034 Reset SHALL take priority over any simultaneous input or output handshake.

Verification
REQ-035 W=16, SIGNED=0: "1234 " -> out_valid one cycle after ' ', out_value=0x04D2, ndigits=4, error=0, overflow=0.
REQ-036 W=16, SIGNED=1: "-42\n" -> out_value=0xFFD6; "-32768 " -> 0x8000, overflow=0; "32768 " -> 0x7FFF, overflow=1.
REQ-037 W=16, SIGNED=0: "65536 " -> out_value=0xFFFF, overflow=1; "000001 " with MAX_DIGITS=5 -> overflow=1.
REQ-038 "12a4 7 " -> first result error=1, value 0; second result 7; "  \r\n9 " -> leading terminators ignored, value 9.
REQ-039 With out_ready held 0 for 10 cycles after "5 ": in_ready=0 and outputs stable throughout; "6 " queued by the source SHALL be parsed only after the handshake.
REQ-040 reset_n pulsed low after "98" -> then "7 " SHALL produce 7, not 987; with in_valid toggled randomly, "1234 " SHALL still yield 0x04D2.

Source files
------------

// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser: converts a stream of ASCII decimal tokens into binary values.
// Tokens are separated by space, LF or CR. An optional leading '-' is accepted
// when SIGNED is set. Each token produces one result that is held until consumed.
module ascii_dec_parser #(
  parameter int unsigned BIN_WIDTH  = 16,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [BIN_WIDTH-1:0]             out_value,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_error,
  output logic                             out_overflow,
  output logic [$clog2(MAX_DIGITS+2)-1:0]  out_ndigits
);

  // Four extra bits keep acc*10+9 exact for any acc up to the limit.
  localparam int unsigned ACC_W  = BIN_WIDTH + 4;
  localparam int unsigned NDIG_W = $clog2(MAX_DIGITS + 2);

  localparam logic [ACC_W-1:0]  LIM_UNS  = ACC_W'({BIN_WIDTH{1'b1}});
  localparam logic [ACC_W-1:0]  LIM_POS  = ACC_W'({(BIN_WIDTH-1){1'b1}});
  localparam logic [ACC_W-1:0]  LIM_NEG  = LIM_POS + ACC_W'(1);
  localparam logic [NDIG_W-1:0] NDIG_MAX = NDIG_W'(MAX_DIGITS);
  localparam logic [NDIG_W-1:0] NDIG_SAT = NDIG_W'(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    SKIP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic [NDIG_W-1:0]    ndigits_q, ndigits_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [BIN_WIDTH-1:0] out_value_q, out_value_d;
  logic                 out_error_q, out_error_d;
  logic                 out_overflow_q, out_overflow_d;

  logic                 take;
  logic                 is_digit;
  logic                 is_term;
  logic                 is_minus;

  logic [ACC_W-1:0]     limit;
  logic [ACC_W-1:0]     acc_base;
  logic [NDIG_W-1:0]    nd_base;
  logic                 ovf_base;
  logic [ACC_W-1:0]     acc_mac;
  logic [NDIG_W-1:0]    nd_inc;
  logic                 dig_ovf;
  logic [ACC_W-1:0]     acc_dig;
  logic [ACC_W-1:0]     acc_out;
  logic                 finish;
  logic                 tok_err;

  assign take     = in_valid && in_ready_q;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_term  = (in_data == 8'h20) || (in_data == 8'h0A) || (in_data == 8'h0D);
  assign is_minus = (in_data == 8'h2D);

  // Accumulate one digit: multiply-add, range check and saturation.
  always_comb begin
    limit = LIM_UNS;
    if (SIGNED != 0) begin
      limit = neg_q ? LIM_NEG : LIM_POS;
    end
    acc_base = (state_q == IDLE) ? '0 : acc_q;
    nd_base  = (state_q == IDLE) ? '0 : ndigits_q;
    ovf_base = (state_q == IDLE) ? 1'b0 : ovf_q;
    acc_mac  = acc_base * ACC_W'(10) + ACC_W'(in_data[3:0]);
    nd_inc   = (nd_base == NDIG_SAT) ? nd_base : nd_base + NDIG_W'(1);
    dig_ovf  = ovf_base || (acc_mac > limit) || (nd_inc > NDIG_MAX);
    acc_dig  = dig_ovf ? limit : acc_mac;
    acc_out  = neg_q ? (ACC_W'(0) - acc_q) : acc_q;
  end

  // Token FSM: next state, working registers and held result.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    neg_d          = neg_q;
    err_d          = err_q;
    ovf_d          = ovf_q;
    ndigits_d      = ndigits_q;
    in_ready_d     = in_ready_q;
    out_valid_d    = out_valid_q;
    out_value_d    = out_value_q;
    out_error_d    = out_error_q;
    out_overflow_d = out_overflow_q;
    finish         = 1'b0;
    tok_err        = err_q || (ndigits_q == '0);

    case (state_q)
      IDLE: begin
        if (take) begin
          if (is_digit) begin
            acc_d     = acc_dig;
            ndigits_d = nd_inc;
            ovf_d     = dig_ovf;
            state_d   = NUM;
          end else if (is_term) begin
            state_d = IDLE;
          end else if (is_minus && (SIGNED != 0)) begin
            neg_d     = 1'b1;
            ndigits_d = '0;
            state_d   = NUM;
          end else begin
            err_d   = 1'b1;
            state_d = SKIP;
          end
        end
      end
      NUM: begin
        if (take) begin
          if (is_digit) begin
            acc_d     = acc_dig;
            ndigits_d = nd_inc;
            ovf_d     = dig_ovf;
          end else if (is_term) begin
            finish = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = SKIP;
          end
        end
      end
      SKIP: begin
        if (take && is_term) begin
          finish = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d        = IDLE;
          acc_d          = '0;
          neg_d          = 1'b0;
          err_d          = 1'b0;
          ovf_d          = 1'b0;
          ndigits_d      = '0;
          in_ready_d     = 1'b1;
          out_valid_d    = 1'b0;
          out_value_d    = '0;
          out_error_d    = 1'b0;
          out_overflow_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Terminator closes the token; a malformed token reports zero and no overflow.
    if (finish) begin
      state_d        = DONE;
      in_ready_d     = 1'b0;
      out_valid_d    = 1'b1;
      out_error_d    = tok_err;
      out_overflow_d = ovf_q && !tok_err;
      out_value_d    = tok_err ? '0 : acc_out[BIN_WIDTH-1:0];
      err_d          = tok_err;
      ovf_d          = ovf_q && !tok_err;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      neg_q          <= 1'b0;
      err_q          <= 1'b0;
      ovf_q          <= 1'b0;
      ndigits_q      <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_value_q    <= '0;
      out_error_q    <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      neg_q          <= neg_d;
      err_q          <= err_d;
      ovf_q          <= ovf_d;
      ndigits_q      <= ndigits_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_value_q    <= out_value_d;
      out_error_q    <= out_error_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign out_error    = out_error_q;
  assign out_overflow = out_overflow_q;
  assign out_ndigits  = ndigits_q;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Bench for ascii_dec_parser: an unsigned and a signed instance share one byte
// stream and one out_ready; results are checked against a token-level model.
module tb_ascii_dec_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic        u_in_ready, s_in_ready;
  logic [15:0] u_value, s_value;
  logic        u_valid, s_valid;
  logic        u_err, s_err;
  logic        u_ovf, s_ovf;
  logic [2:0]  u_nd, s_nd;

  ascii_dec_parser #(.BIN_WIDTH(16), .SIGNED(0), .MAX_DIGITS(5)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(u_in_ready), .out_value(u_value), .out_valid(u_valid),
    .out_ready(out_ready), .out_error(u_err), .out_overflow(u_ovf),
    .out_ndigits(u_nd)
  );

  ascii_dec_parser #(.BIN_WIDTH(16), .SIGNED(1), .MAX_DIGITS(5)) s_dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_value(s_value), .out_valid(s_valid),
    .out_ready(out_ready), .out_error(s_err), .out_overflow(s_ovf),
    .out_ndigits(s_nd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    bit          err;
    bit          ovf;
    int          nd;
  } res_t;

  res_t exp_u[$];
  res_t exp_s[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rdy_hold = 1'b1;
  bit   gaps_on  = 1'b0;
  bit   in_tok   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_term(input byte b);
    return (b == 8'h20) || (b == 8'h0A) || (b == 8'h0D);
  endfunction

  // Token-level reference: value of the decimal text with clamping to the range.
  function automatic res_t ref_parse(input byte tok[$], input bit sgn);
    res_t   r;
    bit     neg;
    bit     bad;
    int     st;
    int     n;
    longint mag;
    longint lim;
    longint v;
    neg = sgn && (tok[0] == 8'h2D);
    st  = neg ? 1 : 0;
    n   = tok.size() - st;
    bad = (n == 0);
    mag = 0;
    for (int i = st; i < tok.size(); i++) begin
      if (tok[i] < 8'h30 || tok[i] > 8'h39) bad = 1'b1;
      else if (mag <= 64'd100000000) mag = mag * 10 + longint'(tok[i] - 8'h30);
    end
    lim   = !sgn ? 65535 : (neg ? 32768 : 32767);
    r.err = bad;
    r.ovf = !bad && ((n > 5) || (mag > lim));
    v     = r.ovf ? lim : mag;
    if (neg) v = -v;
    r.val = bad ? 16'h0000 : 16'(v);
    r.nd  = (n > 6) ? 6 : n;
    return r;
  endfunction

  // Present one byte, optionally after idle cycles carrying junk with in_valid low.
  task automatic send_byte(input byte b);
    int gaps;
    int cnt;
    gaps = gaps_on ? $urandom_range(0, 3) : 0;
    repeat (gaps) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!u_in_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (is_term(b)) begin
      if (in_tok) begin
        check("latency_u_valid", u_valid, 1);
        check("latency_s_valid", s_valid, 1);
      end
      in_tok = 1'b0;
    end else begin
      in_tok = 1'b1;
    end
  endtask

  task automatic send_q(input byte q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  // Queue expectations for every complete token, then drive the bytes.
  task automatic run_q(input byte q[$]);
    byte tok[$];
    foreach (q[i]) begin
      if (is_term(q[i])) begin
        if (tok.size() > 0) begin
          exp_u.push_back(ref_parse(tok, 1'b0));
          exp_s.push_back(ref_parse(tok, 1'b1));
        end
        tok.delete();
      end else begin
        tok.push_back(q[i]);
      end
    end
    send_q(q);
  endtask

  function automatic void str2q(input string s, output byte q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(byte'(s[i]));
  endfunction

  task automatic run_str(input string s);
    byte q[$];
    str2q(s, q);
    run_q(q);
  endtask

  task automatic send_str(input string s);
    byte q[$];
    str2q(s, q);
    send_q(q);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((exp_u.size() != 0 || u_valid) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 500) check("drain_timeout", 0, 1);
  endtask

  // Output side: random out_ready, hold-stability checks, scoreboard on handshake.
  initial begin : consumer
    logic [63:0] snap;
    logic [63:0] cur;
    bit          prev_valid;
    bit          prev_rdy;
    res_t        ru;
    res_t        rs;
    prev_valid = 1'b0;
    prev_rdy   = 1'b0;
    snap       = '0;
    out_ready  = 1'b0;
    forever begin
      @(negedge clk);
      cur = {18'd0, u_value, u_err, u_ovf, u_nd, s_value, s_err, s_ovf, s_nd};
      if (reset_n && u_valid) begin
        check("in_ready_u_in_done", u_in_ready, 0);
        check("in_ready_s_in_done", s_in_ready, 0);
        if (prev_valid && !prev_rdy) check("hold_stable", cur, snap);
      end
      snap       = cur;
      prev_valid = u_valid && reset_n;
      out_ready  = rdy_hold ? 1'b0 : 1'($urandom_range(0, 1));
      prev_rdy   = out_ready;
      if (u_valid && out_ready) begin
        check("s_valid_at_hs", s_valid, 1);
        if (exp_u.size() == 0 || exp_s.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          ru = exp_u.pop_front();
          rs = exp_s.pop_front();
          check("u_value", u_value, ru.val);
          check("u_error", u_err, ru.err);
          check("u_overflow", u_ovf, ru.ovf);
          if (!ru.err) check("u_ndigits", u_nd, ru.nd);
          check("s_value", s_value, rs.val);
          check("s_error", s_err, rs.err);
          check("s_overflow", s_ovf, rs.ovf);
          if (!rs.err) check("s_ndigits", s_nd, rs.nd);
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin : main
    byte q[$];
    byte terms[3];
    int  len;
    terms[0] = 8'h20;
    terms[1] = 8'h0A;
    terms[2] = 8'h0D;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_u_valid", u_valid, 0);
    check("rst_u_value", u_value, 0);
    check("rst_u_error", u_err, 0);
    check("rst_u_overflow", u_ovf, 0);
    check("rst_u_ndigits", u_nd, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_s_value", s_value, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst_u", u_in_ready, 1);
    check("in_ready_after_rst_s", s_in_ready, 1);
    rdy_hold = 1'b0;

    run_str("1234 ");
    run_str("-42\n");
    run_str("-32768 ");
    run_str("32768 ");
    run_str("65536 ");
    run_str("000001 ");
    run_str("12a4 7 ");
    run_str("  \r\n9 ");
    run_str("- ");
    drain();

    // Consumer stalls for 10 cycles while the next token waits at the source.
    rdy_hold = 1'b1;
    run_str("5 ");
    fork
      run_str("6 ");
      begin
        repeat (10) @(negedge clk);
        rdy_hold = 1'b0;
      end
    join
    drain();

    // Reset mid-token, with a byte offered during reset.
    rdy_hold = 1'b1;
    send_str("98");
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(negedge clk);
    check("midrst_u_ndigits", u_nd, 0);
    check("midrst_u_valid", u_valid, 0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    in_tok   = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", u_in_ready, 1);
    check("midrst_ndigits_after", u_nd, 0);
    rdy_hold = 1'b0;
    run_str("7 ");
    drain();

    // Reset while a result is pending discards it.
    rdy_hold = 1'b1;
    send_str("5 ");
    repeat (2) @(negedge clk);
    check("pending_valid", u_valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    in_tok  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("donerst_u_valid", u_valid, 0);
      check("donerst_s_valid", s_valid, 0);
    end
    rdy_hold = 1'b0;

    // Random in_valid gaps.
    gaps_on = 1'b1;
    run_str("1234 ");

    // Random tokens.
    for (int t = 0; t < 60; t++) begin
      q.delete();
      if ($urandom_range(0, 2) == 0) q.push_back(8'h2D);
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) q.push_back(byte'(8'h30 + 8'($urandom_range(0, 9))));
      if (q.size() > 0 && $urandom_range(0, 5) == 0)
        q[$urandom_range(0, q.size() - 1)] = ($urandom_range(0, 1) == 0) ? 8'h61 : 8'h2B;
      q.push_back(terms[$urandom_range(0, 2)]);
      if ($urandom_range(0, 3) == 0) q.push_back(terms[$urandom_range(0, 2)]);
      run_q(q);
    end
    drain();
    check("queue_empty_end", 64'(exp_u.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
